// File: rtl/fifo_rd_axis_adapter.sv
// Read-side adapter between an async FIFO read port and an AXI-Stream master.
// Reads are issued against a credit that covers both buffered words and reads still in
// flight, so the prefetch buffer can never overflow and one word per clock is sustained
// despite the FIFO's fixed read latency.
module fifo_rd_axis_adapter #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                              clk,
   input  logic                              arst_n,
   input  logic                              clear,
   output logic                              fifo_rd_en,
   input  logic                              fifo_rd_empty,
   input  logic                              fifo_rd_dv,
   input  logic [DATA_WIDTH-1:0]             fifo_rd_data,
   output logic                              m_tvalid,
   input  logic                              m_tready,
   output logic [DATA_WIDTH-1:0]             m_tdata,
   output logic [$clog2(READ_LATENCY+2)-1:0] level,
   output logic                              err_unexp_dv,
   output logic                              err_miss_dv
);

   localparam int unsigned Depth = READ_LATENCY + 1;
   localparam int unsigned LvlW  = $clog2(Depth + 1);
   localparam int unsigned PtrW  = $clog2(Depth);
   localparam int unsigned CntW  = LvlW + 1;
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] DepthC  = CntW'(Depth);

   logic [DATA_WIDTH-1:0]   mem_q [Depth];
   logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]         occ_q, occ_d;
   logic [READ_LATENCY-1:0] pend_q, pend_d, discard_q, discard_d;
   logic                    run_q;
   logic                    err_unexp_q, err_unexp_d, err_miss_q, err_miss_d;
   logic                    exp_dv, exp_discard, push, pop;
   logic [CntW-1:0]         inflight, credit_used;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   // The oldest in-flight slot is the one whose data is due this cycle.
   assign exp_dv      = pend_q[READ_LATENCY-1];
   assign exp_discard = discard_q[READ_LATENCY-1];
   assign m_tvalid    = (occ_q != '0);
   assign m_tdata     = mem_q[rd_ptr_q];
   assign level       = occ_q;
   assign pop         = m_tvalid & m_tready;
   // A word returned for a flushed slot, or during clear itself, is dropped silently.
   assign push        = fifo_rd_dv & exp_dv & ~exp_discard & ~clear;
   assign credit_used = CntW'(occ_q) + inflight - CntW'(pop);
   // run_q keeps reads off until the first clock after reset release.
   assign fifo_rd_en  = run_q & ~fifo_rd_empty & ~clear & (credit_used < DepthC);
   assign err_unexp_dv = err_unexp_q;
   assign err_miss_dv  = err_miss_q;

   // Count reads still in flight.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
         inflight = inflight + CntW'(pend_q[i]);
      end
   end

   // Buffer pointers and occupancy; clear empties the buffer outright.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         occ_d = occ_q + LvlW'(push) - LvlW'(pop);
      end
   end

   // Shift the in-flight pipe; clear marks every pending slot as discard.
   always_comb begin
      pend_d       = '0;
      discard_d    = '0;
      pend_d[0]    = fifo_rd_en;
      discard_d[0] = 1'b0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
         pend_d[i]    = pend_q[i-1];
         discard_d[i] = clear ? pend_q[i-1] : discard_q[i-1];
      end
   end

   // Sticky protocol error flags.
   always_comb begin
      err_unexp_d = err_unexp_q | (fifo_rd_dv & ~exp_dv);
      err_miss_d  = err_miss_q | (exp_dv & ~fifo_rd_dv);
   end

   // Control state registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         run_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         pend_q      <= '0;
         discard_q   <= '0;
         err_unexp_q <= 1'b0;
         err_miss_q  <= 1'b0;
      end else begin
         run_q       <= 1'b1;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         pend_q      <= pend_d;
         discard_q   <= discard_d;
         err_unexp_q <= err_unexp_d;
         err_miss_q  <= err_miss_d;
      end
   end

   // Prefetch storage; reset to zero so m_tdata reads 0 out of reset.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= fifo_rd_data;
      end
   end

endmodule
